rc5_key_expand: RTL
===================

// Module: rc5_key_expand
// PURPOSE
//   RC5-32/ROUNDS/16 key schedule: expands the 128-bit user key into the S table of
//   T = 2*ROUNDS+2 32-bit round subkeys. Sits directly upstream of the RC5
//   encrypt/decrypt core (algo), which reads S[] through an asynchronous read port.
//   Runs once per key load. The table stays valid until the next accepted start.
// PARAMETERS
//   ROUNDS   12   RC5 round count r. T = 2*ROUNDS+2 (26 at the default).
//   KEYWORDS 4    key length c, in 32-bit words (fixed at 4 for a 128-bit key).
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-low reset
//   start      in   1    pulse: capture key and begin expansion (accepted only in IDLE)
//   key        in   128  user key, little-endian byte order: L[0] = key[31:0]
//   busy       out  1    high while in INIT or MIX
//   key_valid  out  1    S table complete and stable
//   s_rd_addr  in   5    subkey index 0..T-1
//   s_rd_data  out  32   S[s_rd_addr], combinational; X-free but undefined for addr >= T
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; busy=0; key_valid=0. S and L contents are not reset.
//   FSM states:
//   - IDLE: on start=1, capture key into L[0..3], set i=0, go to INIT. key_valid drops the
//     same edge.
//   - INIT: T cycles, one per cycle: S[i] = P32 + i*Q32 (mod 2^32), i=0..T-1. Then go to
//     MIX with A=B=i=j=0.
//   - MIX: N = 3*max(T,KEYWORDS) cycles (78 at the default), one step per cycle:
//       A' = rotl(S[i]+A+B, 3);  B' = rotl(L[j]+A'+B, (A'+B)[4:0])
//       S[i]=A'; L[j]=B'; i = (i==T-1)?0:i+1; j = (j==KEYWORDS-1)?0:j+1
//     After step N-1, go to DONE.
//   - DONE: key_valid=1, busy=0. Equivalent to IDLE for start acceptance.
//   Arithmetic: all adds are mod 2^32. The rotate amount uses only the low 5 bits.
//   Latency: key_valid rises T+N+1 cycles after the start-accepting edge (105 at the
//   default).
//   Boundaries:
//   - start while busy: ignored; the key is not recaptured.
//   - start in DONE: restarts; key_valid=0 from the next edge.
//   - rst asserted mid-INIT/MIX: immediate IDLE, busy=0, key_valid=0. The partial table
//     is discarded.
//   - s_rd_addr may change every cycle. Data is guaranteed correct only while
//     key_valid=1.
// CONFIGURATION
//   RC5_KS_ZEROIZE_EN defined:
//   - On the DONE entry edge, L[0..3] are cleared to 0.
//   - In any state, rst=0 clears L and S asynchronously.
//   - No key-derived material remains except S.
//   RC5_KS_ZEROIZE_EN undefined: L keeps its final MIX values; S and L are untouched by
//   reset. Cycle timing is identical in both builds.
// STRUCTURE
//   Package rc5_pkg:
//   - constants P32=32'hB7E15163, Q32=32'h9E3779B9, W=32
//   - function rotl32(x, amt[4:0])
//   - FSM enum {KS_IDLE, KS_INIT, KS_MIX, KS_DONE}
//   The same package is shared with the encrypt/decrypt core.
//   Sub-module rc5_ks_mix (combinational): inputs S[i], L[j], A, B; outputs A', B'.
//   The FSM, counters and S/L register arrays live in rc5_key_expand.
// TESTING
//   1. key=0, start pulse -> busy=1 next cycle; key_valid=1 exactly 105 cycles after
//      the start edge; S[0..25] match the C reference model.
//   2. key=128'h0F0E..0100 (bytes 00..0F) -> all 26 S words match the model. Feeding
//      algo with pt=0 gives the model ciphertext.
//   3. start re-pulsed at cycle 40 of MIX -> ignored; final S equals the first key's
//      expansion; latency still 105.
//   4. rst=0 at cycle 50 -> busy=0 and key_valid=0 immediately. A new start then
//      produces a correct table in 105 cycles.
//   5. start in DONE with a new key -> key_valid=0 next edge; the new table is correct.
//   6. With RC5_KS_ZEROIZE_EN: after key_valid, internal L[0..3]==0 and S is unchanged.
//      Without it: L holds its final MIX values.

Source files
------------

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared RC5-32 definitions for the key schedule and the
// encrypt/decrypt core.
//   W, P32, Q32  : word width and the RC5 magic constants
//   rotl32()     : 32-bit rotate left by a 5-bit amount
//   ks_state_e   : key-schedule FSM states
package rc5_pkg;

    localparam int          W   = 32;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_INIT = 2'd1,
        KS_MIX  = 2'd2,
        KS_DONE = 2'd3
    } ks_state_e;

    // Right-shift by (-amt mod 32) keeps amt==0 a plain pass-through.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
        logic [4:0] w_ramt;
        w_ramt = 5'd0 - amt;
        return (x << amt) | (x >> w_ramt);
    endfunction

endpackage

// File: rtl/rc5_ks_mix.sv
// rc5_ks_mix: one combinational step of the RC5 key-mixing loop.
//   i_s_i  : current S[i]
//   i_l_j  : current L[j]
//   i_a    : running A
//   i_b    : running B
//   o_a    : A' = rotl(S[i]+A+B, 3)
//   o_b    : B' = rotl(L[j]+A'+B, (A'+B)[4:0])
module rc5_ks_mix
    import rc5_pkg::*;
(
    input  logic [31:0] i_s_i,
    input  logic [31:0] i_l_j,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_a,
    output logic [31:0] o_b
);

    logic [31:0] w_a_nxt;
    logic [31:0] w_ab;

    assign w_a_nxt = rotl32(i_s_i + i_a + i_b, 5'd3);
    assign w_ab    = w_a_nxt + i_b;
    assign o_a     = w_a_nxt;
    assign o_b     = rotl32(i_l_j + w_ab, w_ab[4:0]);

endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-32/ROUNDS/16 key schedule. Expands a 128-bit key into
// the S table of T = 2*ROUNDS+2 subkeys, read through an asynchronous port.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : pulse, capture key and expand (accepted in IDLE/DONE only)
//   key        : user key, L[0] = key[31:0]
//   busy       : high in INIT and MIX
//   key_valid  : S table complete and stable
//   s_rd_addr  : subkey index 0..T-1
//   s_rd_data  : S[s_rd_addr], zero for addresses >= T
// Build option: RC5_KS_ZEROIZE_EN clears L on DONE entry and clears S and L
// on reset. Cycle timing is the same either way.
//
// state   | meaning
// KS_IDLE | waiting for start after reset
// KS_INIT | S[i] = P32 + i*Q32, one word per cycle, T cycles
// KS_MIX  | 3*max(T,KEYWORDS) mixing steps, one per cycle
// KS_DONE | table valid; start restarts the schedule
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int ROUNDS   = 12,
    parameter int KEYWORDS = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*KEYWORDS-1:0] key,
    output logic                  busy,
    output logic                  key_valid,
    input  logic [4:0]            s_rd_addr,
    output logic [31:0]           s_rd_data
);

    localparam int T  = 2*ROUNDS + 2;
    localparam int N  = 3 * ((T > KEYWORDS) ? T : KEYWORDS);
    localparam int CW = $clog2(N);
    localparam int JW = $clog2(KEYWORDS);

    localparam logic [4:0]    T_LAST = 5'(T - 1);
    localparam logic [JW-1:0] J_LAST = JW'(KEYWORDS - 1);
    localparam logic [CW-1:0] INIT_LOAD = CW'(T - 1);
    localparam logic [CW-1:0] MIX_LOAD  = CW'(N - 1);

    ks_state_e      r_state;
    logic           r_busy;
    logic           r_key_valid;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_i;
    logic [JW-1:0]  r_j;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [31:0]    r_pq;
    logic [31:0]    r_s [T];
    logic [31:0]    r_l [KEYWORDS];

    logic [31:0]    w_s_i;
    logic [31:0]    w_l_j;
    logic [31:0]    w_a_nxt;
    logic [31:0]    w_b_nxt;
    logic           w_accept;
    logic           w_s_we;
    logic [31:0]    w_s_wdata;
    logic           w_l_we;
    logic           w_mix_last;

    assign w_s_i = r_s[r_i];
    assign w_l_j = r_l[r_j];

    rc5_ks_mix u_mix (
        .i_s_i (w_s_i),
        .i_l_j (w_l_j),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_a   (w_a_nxt),
        .o_b   (w_b_nxt)
    );

    assign w_accept   = start && (r_state == KS_IDLE || r_state == KS_DONE);
    assign w_mix_last = (r_state == KS_MIX) && (r_cnt == '0);
    assign w_l_we     = (r_state == KS_MIX);

    always_comb begin
        w_s_we    = 1'b0;
        w_s_wdata = w_a_nxt;
        if (r_state == KS_INIT) begin
            w_s_we    = 1'b1;
            w_s_wdata = r_pq;
        end else if (r_state == KS_MIX) begin
            w_s_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= KS_IDLE;
            r_busy      <= 1'b0;
            r_key_valid <= 1'b0;
            r_cnt       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_pq        <= '0;
        end else begin
            case (r_state)
                KS_IDLE, KS_DONE: begin
                    if (start) begin
                        r_state     <= KS_INIT;
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                        r_i         <= '0;
                        r_cnt       <= INIT_LOAD;
                        r_pq        <= P32;
                    end else if (r_state == KS_DONE) begin
                        // Valid one cycle after DONE entry, giving T+N+1 latency.
                        r_key_valid <= 1'b1;
                    end
                end
                KS_INIT: begin
                    r_pq <= r_pq + Q32;
                    if (r_cnt == '0) begin
                        r_state <= KS_MIX;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_cnt   <= MIX_LOAD;
                    end else begin
                        r_i     <= r_i + 5'd1;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                KS_MIX: begin
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                    r_i <= (r_i == T_LAST) ? 5'd0 : r_i + 5'd1;
                    r_j <= (r_j == J_LAST) ? '0 : r_j + 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= KS_DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= KS_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RC5_KS_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < T; k++) r_s[k] <= '0;
            for (int k = 0; k < KEYWORDS; k++) r_l[k] <= '0;
        end else begin
            if (w_s_we) r_s[r_i] <= w_s_wdata;
            if (w_accept) begin
                for (int k = 0; k < KEYWORDS; k++) r_l[k] <= key[32*k +: 32];
            end else if (w_mix_last) begin
                for (int k = 0; k < KEYWORDS; k++) r_l[k] <= '0;
            end else if (w_l_we) begin
                r_l[r_j] <= w_b_nxt;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_s_we) r_s[r_i] <= w_s_wdata;
        if (w_accept) begin
            for (int k = 0; k < KEYWORDS; k++) r_l[k] <= key[32*k +: 32];
        end else if (w_l_we) begin
            r_l[r_j] <= w_b_nxt;
        end
    end
`endif

    assign busy      = r_busy;
    assign key_valid = r_key_valid;
    assign s_rd_data = (s_rd_addr < 5'(T)) ? r_s[s_rd_addr] : 32'd0;

endmodule
